// File: rtl/dmem_mmio_bridge.sv
// Routes the processor dmem port to the data RAM or to an MMIO bank (LED, switches, timer, TX FIFO).
// Optional timer compare register and interrupt enabled with `define TIMER_IRQ_EN.
module dmem_mmio_bridge #(
    parameter int          RAM_AW     = 12,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFFFF00
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       address_dmem,
    input  logic [31:0]       data,
    input  logic              wren,
    output logic [31:0]       q_dmem,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_data,
    output logic              ram_wren,
    input  logic [31:0]       ram_q,
    input  logic [15:0]       switches,
    output logic [15:0]       leds,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              irq
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        SEL_NONE, SEL_RAM, SEL_LED, SEL_SW, SEL_TIMER, SEL_TXDATA, SEL_TXSTAT, SEL_CMP
    } sel_t;

    sel_t          sel_now;
    sel_t          sel_reg;
    logic [31:0]   rd_next;
    logic [31:0]   rd_reg;
    logic [31:0]   mmio_off;

    logic [15:0]   leds_reg;
    logic [15:0]   sw_meta_reg;
    logic [15:0]   sw_sync_reg;
    logic [31:0]   timer_reg;
    logic [31:0]   timer_next;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          ovf_reg;
    logic          ovf_next;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push_req;
    logic          do_push;
    logic          do_pop;
    logic          ovf_set;
    logic          ovf_clear;

    assign mmio_off = address_dmem - MMIO_BASE;

    always_comb begin
        sel_now = SEL_NONE;
        if (address_dmem[31:RAM_AW] == '0) begin
            sel_now = SEL_RAM;
        end else if (address_dmem >= MMIO_BASE) begin
            case (mmio_off)
                32'd0:   sel_now = SEL_LED;
                32'd1:   sel_now = SEL_SW;
                32'd2:   sel_now = SEL_TIMER;
                32'd3:   sel_now = SEL_TXDATA;
                32'd4:   sel_now = SEL_TXSTAT;
`ifdef TIMER_IRQ_EN
                32'd5:   sel_now = SEL_CMP;
`endif
                default: sel_now = SEL_NONE;
            endcase
        end
    end

    assign ram_addr = address_dmem[RAM_AW-1:0];
    assign ram_data = data;
    assign ram_wren = wren && (sel_now == SEL_RAM);

    // A timer write overrides the increment; reads return the post-update value.
    assign timer_next = (wren && sel_now == SEL_TIMER) ? data : timer_reg + 32'd1;

    assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign tx_valid   = !fifo_empty;
    assign tx_data    = fifo_mem[rd_ptr_reg];
    assign do_pop     = tx_valid && tx_ready;
    assign push_req   = wren && (sel_now == SEL_TXDATA);
    // When full, a simultaneous pop frees the slot the push lands in.
    assign do_push    = push_req && (!fifo_full || do_pop);
    assign ovf_set    = push_req && fifo_full && !do_pop;
    assign ovf_clear  = !wren && (sel_now == SEL_TXSTAT);
    assign ovf_next   = (ovf_reg && !ovf_clear) || ovf_set;

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

`ifdef TIMER_IRQ_EN
    logic [31:0] cmp_reg;
    logic        irq_reg;
    logic        cmp_we;

    assign cmp_we = wren && (sel_now == SEL_CMP);
    assign irq    = irq_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            cmp_reg <= 32'hFFFFFFFF;
            irq_reg <= 1'b0;
        end else begin
            if (cmp_we) begin
                cmp_reg <= data;
                irq_reg <= 1'b0;
            end else if (timer_reg == cmp_reg) begin
                irq_reg <= 1'b1;
            end
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_next = 32'd0;
        case (sel_now)
            SEL_LED:    rd_next = {16'd0, leds_reg};
            SEL_SW:     rd_next = {16'd0, sw_sync_reg};
            SEL_TIMER:  rd_next = timer_next;
            SEL_TXDATA: rd_next = {{(32-CW){1'b0}}, count_reg};
            SEL_TXSTAT: rd_next = {29'd0, ovf_reg, fifo_empty, fifo_full};
`ifdef TIMER_IRQ_EN
            SEL_CMP:    rd_next = cmp_reg;
`endif
            default:    rd_next = 32'd0;
        endcase
    end

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
            always_ff @(posedge clock) begin
                if (reset) begin
                    fifo_mem[gi] <= 8'd0;
                end else if (do_push && wr_ptr_reg == PW'(gi)) begin
                    fifo_mem[gi] <= data[7:0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            sel_reg     <= SEL_NONE;
            rd_reg      <= 32'd0;
            leds_reg    <= 16'd0;
            sw_meta_reg <= 16'd0;
            sw_sync_reg <= 16'd0;
            timer_reg   <= 32'd0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            sel_reg     <= sel_now;
            rd_reg      <= rd_next;
            sw_meta_reg <= switches;
            sw_sync_reg <= sw_meta_reg;
            timer_reg   <= timer_next;
            count_reg   <= count_next;
            ovf_reg     <= ovf_next;
            if (wren && sel_now == SEL_LED) leds_reg <= data[15:0];
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
    end

    assign leds   = leds_reg;
    assign q_dmem = (sel_reg == SEL_RAM) ? ram_q : rd_reg;

endmodule
